// File: rtl/vsg_pkg.sv
// Shared definitions for the video source generator: FSM encoding, pattern codes, bar colours.
package vsg_pkg;

  localparam int CNT_W = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRID  = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Index 8 marks the remainder pixels right of the last full bar.
  function automatic logic [23:0] bar_colour(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_colour = BAR_WHITE;
      4'd1:    bar_colour = BAR_YELLOW;
      4'd2:    bar_colour = BAR_CYAN;
      4'd3:    bar_colour = BAR_GREEN;
      4'd4:    bar_colour = BAR_MAGENTA;
      4'd5:    bar_colour = BAR_RED;
      4'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vsg_timing.sv
// Horizontal/vertical raster counters with active-area and sync-window decode.
module vsg_timing
  import vsg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic line_end;

  assign line_end  = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Line layout: active, front porch, sync, back porch (same order vertically).
  assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hsync_act = (h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                     (h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_act = (v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                     (v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/video_src_gen.sv
// Test-pattern video source: IDLE/RUN/DRAIN control, pattern generation, registered outputs.
// Optional VSG_MOVING_PATTERN_EN adds a per-frame horizontal scroll to patterns 0-2.
module video_src_gen
  import vsg_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pix_clk_i,
  input  logic        sys_rst,
  input  logic        src_en_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [23:0] RGB_data_o,
  output logic        pix_en_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o,
  output logic [1:0]  fsm_state
);

  localparam int BAR_W    = H_ACTIVE >> 3;
  localparam int MOD_ITER = 256 / H_ACTIVE + 1;

  logic [1:0]       state, state_nxt;
  logic             go, frame_first;
  logic [CNT_W-1:0] h_cnt, v_cnt, x_off, bar_x;
  logic             active, hsync_act, vsync_act, frame_end;
  logic [1:0]       pat_q, sel;
  logic [23:0]      solid_q, solid_sel, pixel;
  logic [3:0]       bar_idx;

  vsg_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(pix_clk_i), .rst(sys_rst), .run(go),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .hsync_act(hsync_act), .vsync_act(vsync_act), .frame_end(frame_end)
  );

  // A run request in IDLE starts the raster in the same cycle, so the first pixel appears one clock later.
  assign go          = (state != ST_IDLE) || src_en_i;
  assign frame_first = go && (h_cnt == '0) && (v_cnt == '0);
  assign fsm_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (src_en_i) state_nxt = ST_RUN;
      ST_RUN:   if (!src_en_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (src_en_i)       state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pix_clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else begin
      state <= state_nxt;
      if (frame_first) begin
        pat_q   <= pattern_sel_i;
        solid_q <= solid_rgb_i;
      end
    end
  end

  // Selections take effect on the first pixel of a frame and hold until the next one.
  assign sel       = frame_first ? pattern_sel_i : pat_q;
  assign solid_sel = frame_first ? solid_rgb_i : solid_q;

`ifdef VSG_MOVING_PATTERN_EN
  logic [7:0] offset;

  always_ff @(posedge pix_clk_i or posedge sys_rst) begin
    if (sys_rst)              offset <= '0;
    else if (go && frame_end) offset <= offset + 8'd1;
  end

  assign x_off = h_cnt + CNT_W'(offset);
`else
  assign x_off = h_cnt;
`endif

  always_comb begin
    bar_x = x_off;
    for (int i = 0; i < MOD_ITER; i++)
      if (bar_x >= CNT_W'(H_ACTIVE)) bar_x = bar_x - CNT_W'(H_ACTIVE);
    bar_idx = '0;
    for (int k = 1; k <= 8; k++)
      if (bar_x >= CNT_W'(k * BAR_W)) bar_idx = 4'(k);
    case (sel)
      PAT_BARS: pixel = bar_colour(bar_idx);
      PAT_GRID: pixel = ((x_off[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)) ? BAR_WHITE : BAR_BLACK;
      PAT_RAMP: pixel = {x_off[7:0], v_cnt[7:0], 8'(x_off[7:0] + v_cnt[7:0])};
      default:  pixel = solid_sel;
    endcase
  end

  always_ff @(posedge pix_clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      RGB_data_o    <= '0;
      pix_en_o      <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
    end else begin
      RGB_data_o    <= (go && active) ? pixel : 24'h0;
      pix_en_o      <= go && active;
      hsync_o       <= (go && hsync_act) ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= (go && vsync_act) ? SYNC_POL : ~SYNC_POL;
      frame_start_o <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_src_gen.sv
// Self-checking bench for video_src_gen on a 22x7 raster: timing, patterns, drain and reset.
module tb_video_src_gen;
  import vsg_pkg::*;

  localparam int HA = 16, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 22
  localparam int VT = VA + VF + VS + VB;  // 7
  localparam int FT = HT * VT;            // 154

  logic        clk = 1'b0;
  logic        rst;
  logic        src_en;
  logic [1:0]  sel;
  logic [23:0] solid;
  logic [23:0] rgb;
  logic        pix_en, hsync, vsync, frame_start;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  video_src_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut (
    .pix_clk_i(clk), .sys_rst(rst), .src_en_i(src_en),
    .pattern_sel_i(sel), .solid_rgb_i(solid),
    .RGB_data_o(rgb), .pix_en_o(pix_en), .hsync_o(hsync), .vsync_o(vsync),
    .frame_start_o(frame_start), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_pix(input int p, input int x, input int y, input logic [23:0] s);
    case (p)
      0: case (x / 2)
           0: exp_pix = 24'hFFFFFF;
           1: exp_pix = 24'hFFFF00;
           2: exp_pix = 24'h00FFFF;
           3: exp_pix = 24'h00FF00;
           4: exp_pix = 24'hFF00FF;
           5: exp_pix = 24'hFF0000;
           6: exp_pix = 24'h0000FF;
           default: exp_pix = 24'h000000;
         endcase
      1: exp_pix = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      2: exp_pix = {8'(x), 8'(y), 8'(x + y)};
      default: exp_pix = s;
    endcase
  endfunction

  task automatic push_frame(input int p, input logic [23:0] s);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        exp_q.push_back(exp_pix(p, x, y, s));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pix_en"}, pix_en, 0);
    check({tag, "_rgb"}, rgb, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // Current sample is frame cycle 0; checks cycles up to stop_at-1 and steps past each.
  task automatic observe_frame(input int chg_line, input int new_sel, input logic [23:0] new_solid,
                               input int drop_line, input int stop_at);
    int x, y;
    logic act;
    for (int c = 0; c < stop_at; c++) begin
      x   = c % HT;
      y   = c / HT;
      act = (x < HA) && (y < VA);
      check("pix_en", pix_en, act);
      check("hsync", hsync, (x >= HA + HF) && (x < HA + HF + HS));
      check("vsync", vsync, (y >= VA + VF) && (y < VA + VF + VS));
      check("frame_start", frame_start, c == 0);
      if (pix_en) begin
        if (exp_q.size() == 0) check("sb_level", exp_q.size(), 1);
        else                   check("rgb", rgb, exp_q.pop_front());
      end else begin
        check("rgb_blank", rgb, 0);
      end
      if (y == chg_line && x == 5) begin
        sel   = 2'(new_sel);
        solid = new_solid;
        push_frame(new_sel, new_solid);
      end
      if (y == drop_line && x == 3) src_en = 1'b0;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [23:0] solid_a, solid_b;
    solid_a = 24'($urandom_range(1, 32'hFFFFFE));
    solid_b = 24'($urandom_range(1, 32'hFFFFFE));

    rst = 1'b1; src_en = 1'b0; sel = 2'd0; solid = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    step();
    step();
    check_idle("idle");

    // Bars, then mid-frame switches chain solid A, solid B, ramp, grid, bars.
    sel = PAT_BARS;
    push_frame(0, 24'h0);
    src_en = 1'b1;
    step();
    observe_frame(2, 3, solid_a, -1, FT);
    observe_frame(1, 3, solid_b, -1, FT);
    observe_frame(2, 2, 24'h0, -1, FT);
    observe_frame(3, 1, 24'h0, -1, FT);
    observe_frame(2, 0, 24'h0, -1, FT);
    // Run request dropped on line 1: frame completes, then idle.
    observe_frame(-1, 0, 24'h0, 1, FT);
    check("sb_drain", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      check_idle("drained");
      step();
    end

    // Re-raise with ramp, then reset mid-line.
    sel = PAT_RAMP;
    push_frame(2, 24'h0);
    src_en = 1'b1;
    step();
    observe_frame(-1, 0, 24'h0, -1, HT + 8);
    check("pre_rst_pix_en", pix_en, 1);
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    exp_q.delete();
    step();
    step();
    check_idle("held_rst");
    rst = 1'b0;
    push_frame(2, 24'h0);
    step();
    observe_frame(-1, 0, 24'h0, -1, FT);
    check("period_fs", frame_start, 1);
    check("period_pix_en", pix_en, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_src_gen.md
VIDEO_SRC_GEN -- requirements
Module: video_src_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter SYNC_POL, default 1, asserted level of hsync_o and vsync_o.
REQ-006 pix_clk_i  in  1  pixel clock, single clock of the block.
REQ-007 sys_rst  in  1  asynchronous, active-high reset.
REQ-008 src_en_i  in  1  run request (tied to ADV7611_config_done in system).
REQ-009 pattern_sel_i  in  2  0 colour bars, 1 grid, 2 ramp, 3 solid.
REQ-010 solid_rgb_i  in  24  colour for pattern 3, {R,G,B}.
REQ-011 RGB_data_o  out  24  pixel {R[23:16],G[15:8],B[7:0]}, zero outside active.
REQ-012 pix_en_o  out  1  high on active pixels only.
REQ-013 hsync_o / vsync_o  out  1 each  sync pulses, level SYNC_POL when asserted.
REQ-014 frame_start_o  out  1  one-cycle pulse on first active pixel of each frame.

Function
REQ-015 Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), v_cnt 0..V_TOTAL-1; h_cnt wraps to 0 and v_cnt advances on the same edge; v_cnt wraps to 0 at V_TOTAL-1 with h wrap.
REQ-016 Ordering per line: active [0,H_ACTIVE), front porch, sync, back porch; same ordering vertically.
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE -> RUN when src_en_i=1, counters start at (0,0).
REQ-018 RUN -> DRAIN when src_en_i falls; DRAIN completes the current frame, then -> IDLE at h/v wrap; src_en_i reasserting during DRAIN -> RUN without frame interruption.
REQ-019 In IDLE: counters held at 0, pix_en_o=0, RGB_data_o=0, syncs deasserted (~SYNC_POL).
REQ-020 All outputs registered; pix_en_o, RGB_data_o, hsync_o, vsync_o mutually aligned, one cycle after the counter value that produces them.
REQ-021 pattern_sel_i and solid_rgb_i sampled only at h_cnt=0,v_cnt=0; mid-frame changes have no effect until next frame.
REQ-022 Colour bars: 8 bars of width H_ACTIVE>>3, order white, yellow, cyan, green, magenta, red, blue, black; bar index from a compare counter, no divider; remainder pixels take black.
REQ-023 Grid: white (24'hFFFFFF) where h_cnt[4:0]==0 or v_cnt[4:0]==0, else black.
REQ-024 Ramp: R=h_cnt[7:0], G=v_cnt[7:0], B=(h_cnt+v_cnt) low 8 bits, modulo 256.
REQ-025 frame_start_o coincides with the first pix_en_o=1 of each frame.

Reset
REQ-026 sys_rst asserted at any time: FSM -> IDLE, counters 0, all outputs to REQ-019 values, frame_start_o=0, within the asserting edge (asynchronous); deassertion synchronous to pix_clk_i.

Configuration
REQ-027 Macro VSG_MOVING_PATTERN_EN defined: 8-bit frame offset increments at each frame wrap and is added to h_cnt for patterns 0-2 (horizontal scroll, mod H_ACTIVE for bars); reset to 0.
REQ-028 Macro absent: no offset register, patterns static.

Structure
REQ-029 Shared package holds FSM state encoding, pattern-select codes and the eight bar colour constants.
REQ-030 One sub-module, vsg_timing, holds h/v counters and sync/active decode; pattern generation stays in video_src_gen.

Verification
REQ-031 H_ACTIVE=16, H_FP/SYNC/BP=2/2/2, V_ACTIVE=4, V 1/1/1, src_en_i=1 -> 16 pix_en_o per line, 4 lines per frame, hsync_o 2 clocks at line offset 18, frame period 22*7=154 clocks.
REQ-032 pattern_sel_i=0, H_ACTIVE=16 -> pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000.
REQ-033 pattern_sel_i=2 -> pixel (5,3) = {8'h05,8'h03,8'h08}.
REQ-034 pattern_sel_i changes 0->3 mid-frame -> current frame stays bars, next frame all solid_rgb_i.
REQ-035 src_en_i dropped at line 1 -> frame completes, then IDLE with outputs 0 and syncs deasserted; re-raise -> frame_start_o after one cycle of latency.
REQ-036 sys_rst pulsed mid-line -> outputs to reset values immediately; restart at (0,0) after release.
